// File: rtl/hi_lo_muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: command opcodes and FSM states.
package hi_lo_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/hi_lo_muldiv_unit_if.sv
// Command/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface hi_lo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, abort,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, abort,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hi_lo_muldiv_unit_datapath.sv
// Iteration datapath: magnitude conversion, shift-add multiply, restoring divide
// and the final sign correction of the product / quotient / remainder.
module hi_lo_muldiv_unit_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             load,
    input  logic             load_div,
    input  logic             load_signed,
    input  logic             step,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // Mul: {partial product, remaining multiplier bits}. Div: low half is the quotient.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   m;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               div_zero;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;

    // An unsigned WIDTH-bit magnitude still holds |most-negative| exactly.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign mag_a     = magnitude(operand_a, load_signed);
    assign mag_b     = magnitude(operand_b, load_signed);
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : {WIDTH{1'b0}})};
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, m};
    assign div_diff  = div_shift[WIDTH-1:0] - m;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            rem      <= '0;
            m        <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (clk_enable) begin
            if (load) begin
                is_div   <= load_div;
                neg_main <= load_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                neg_rem  <= load_signed & operand_a[WIDTH-1];
                div_zero <= load_div && (operand_b == '0);
                rem      <= '0;
                m        <= load_div ? mag_b : mag_a;
                acc      <= {{WIDTH{1'b0}}, (load_div ? mag_a : mag_b)};
            end else if (step) begin
                if (is_div) begin
                    rem <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                    acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
                end else begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                end
            end
        end
    end

    // Divide by zero leaves rem = |a|, so the dividend-sign fixup restores hi = a.
    always_comb begin
        prod = neg_main ? -acc : acc;
        if (is_div) begin
            res_hi = neg_rem ? -rem : rem;
            res_lo = div_zero ? {WIDTH{1'b1}} : (neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// HI/LO register owner for the execute stage: command FSM, iteration counter,
// HI/LO registers and the busy/done handshake around the iterative datapath.
module hi_lo_muldiv_unit
    import hi_lo_muldiv_unit_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_enable,
    hi_lo_muldiv_unit_if.slave  bus
);

    muldiv_state_t    state;
    muldiv_state_t    state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done;

    logic             load;
    logic             load_div;
    logic             load_signed;
    logic             step;
    logic             write_result;
    logic             write_hi;
    logic             write_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign load_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign load_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);

    always_comb begin
        state_next   = state;
        load         = 1'b0;
        step         = 1'b0;
        write_result = 1'b0;
        write_hi     = 1'b0;
        write_lo     = 1'b0;
        case (state)
            ST_IDLE: begin
                // abort outranks a same-cycle start
                if (bus.start && !bus.abort) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_next = ST_MUL;
                            load       = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_next = ST_DIV;
                            load       = 1'b1;
                        end
                        OP_MTHI: write_hi = 1'b1;
                        OP_MTLO: write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(1)) state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next   = ST_IDLE;
                write_result = !bus.abort;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else if (clk_enable) begin
            state <= state_next;
            done  <= write_result;
            if (load)      cnt <= CNT_W'(WIDTH);
            else if (step) cnt <= cnt - CNT_W'(1);
            if (write_result) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (write_hi) hi <= bus.operand_a;
            if (write_lo) lo <= bus.operand_a;
        end
    end

    hi_lo_muldiv_unit_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .load        (load),
        .load_div    (load_div),
        .load_signed (load_signed),
        .step        (step),
        .operand_a   (bus.operand_a),
        .operand_b   (bus.operand_b),
        .res_hi      (res_hi),
        .res_lo      (res_lo)
    );

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Self-checking bench for hi_lo_muldiv_unit: vector table plus random ops through a
// result scoreboard, then hand sequences for MTHI/MTLO, stall, abort and async reset.
module tb_hi_lo_muldiv_unit;
    import hi_lo_muldiv_unit_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    logic clk_enable;

    always #5 clk = ~clk;

    hi_lo_muldiv_unit_if #(.WIDTH(W)) bus ();

    hi_lo_muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t        vecs[10];
    logic [63:0] sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result built from the language's own 64-bit * / % operators.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = '0;
        case (op)
            3'd0: r = sa * sb;
            3'd1: r = ua * ub;
            3'd2: begin
                if (b == '0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sa = sa % sb;
                    r[63:32] = sa[31:0];
                    sa = longint'($signed(a)) / sb;
                    r[31:0] = sa[31:0];
                end
            end
            default: begin
                if (b == '0) r = {a, 32'hFFFF_FFFF};
                else begin
                    ub = ua % ub;
                    r[63:32] = ub[31:0];
                    ub = ua / {32'h0, b};
                    r[31:0] = ub[31:0];
                end
            end
        endcase
        return r;
    endfunction

    // Issue one mul/div, optionally poke a second start or stall clk_enable mid-run.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [63:0] exp,
                          input int poke_at, input int stall_at);
        int          n;
        bit          seen;
        logic [63:0] prior;
        logic [63:0] want;
        prior = {bus.hi, bus.lo};
        sb_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (bus.done) seen = 1'b1;
            else begin
                if (n == 10) check({tag, "_hold_mid"}, {bus.hi, bus.lo}, prior);
                if (poke_at > 0 && n == poke_at) begin
                    bus.start = 1'b1; bus.op = 3'(OP_DIVU); bus.operand_a = 1; bus.operand_b = 1;
                end
                if (poke_at > 0 && n == poke_at + 1) bus.start = 1'b0;
                if (stall_at > 0 && n == stall_at) clk_enable = 1'b0;
                if (stall_at > 0 && n == stall_at + 3) check({tag, "_busy_stall"}, 64'(bus.busy), 64'd1);
                if (stall_at > 0 && n == stall_at + 5) clk_enable = 1'b1;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'(W + 1 + ((stall_at > 0) ? 5 : 0)));
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        if (sb_q.size() == 0) check({tag, "_sb_empty"}, 64'd0, 64'd1);
        else begin
            want = sb_q.pop_front();
            check({tag, "_hi"}, 64'(bus.hi), 64'(want[63:32]));
            check({tag, "_lo"}, 64'(bus.lo), 64'(want[31:0]));
        end
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    task automatic move_to(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          n_done;
        logic [2:0]  rop;
        logic [W-1:0] ra, rb;

        vecs[0] = '{3'(OP_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{3'(OP_MULT),  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{3'(OP_MULT),  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{3'(OP_DIV),   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{3'(OP_DIVU),  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5] = '{3'(OP_DIV),   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{3'(OP_DIVU),  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
        vecs[7] = '{3'(OP_DIV),   32'hFFFF_FFF7, 32'h0000_0000, 32'hFFFF_FFF7, 32'hFFFF_FFFF};
        vecs[8] = '{3'(OP_DIV),   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9] = '{3'(OP_MULTU), 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

        reset = 1'b1;
        clk_enable = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi",   64'(bus.hi),   64'd0);
        check("rst_lo",   64'(bus.lo),   64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   {vecs[i].hi, vecs[i].lo}, -1, -1);

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 2 == 1) ? 32'($urandom) : 32'($urandom_range(0, 9));
            run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb), -1, -1);
        end

        move_to("mthi", 3'(OP_MTHI), 32'hDEAD_BEEF, 32'hDEAD_BEEF, bus.lo);
        move_to("mtlo", 3'(OP_MTLO), 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h0BAD_F00D);

        run_op("poke",  3'(OP_MULT),  32'd5,       32'd6,       64'd30,          5, -1);
        run_op("stall", 3'(OP_MULTU), 32'h0000_1000, 32'h0000_3000, 64'h0300_0000, -1, 12);

        move_to("pre_hi", 3'(OP_MTHI), 32'hAA, 32'hAA, 32'h0300_0000);
        move_to("pre_lo", 3'(OP_MTLO), 32'h55, 32'hAA, 32'h55);

        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'(OP_DIV); bus.operand_a = 32'd100; bus.operand_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'hAA);
        check("abort_lo", 64'(bus.lo), 64'h55);

        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'(OP_DIV); bus.operand_a = 32'd1000; bus.operand_b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset_busy", 64'(bus.busy), 64'd0);
        check("areset_hi",   64'(bus.hi),   64'd0);
        check("areset_lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("areset_idle", 64'(bus.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
